// File: rtl/mem_pkg.sv
// Shared parameters, state encoding and helpers for the mem_responder block.
package mem_pkg;

    localparam int AW     = 15;
    localparam int WORD_W = 16;
    localparam int DEPTH  = 2 ** AW;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Saturating increment for the loaded-word counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'h0001);
    endfunction

endpackage

// File: rtl/mem_rd_port.sv
// Two-stage read pipe: stage 1 holds the address (array read happens on it),
// stage 2 forwards a same-cycle write to that address and registers rdata.
module mem_rd_port
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [AW-1:0]     raddr,
    output logic [AW-1:0]     s1_addr,
    input  logic [WORD_W-1:0] s1_rdata,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rdata
);

    logic [AW-1:0]     addr_r;
    logic              vld1_r;
    logic [WORD_W-1:0] rdata_r;
    logic [WORD_W-1:0] s2_data_s;

    // Stage 1: capture address and whether the request was made while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= '0;
            vld1_r <= 1'b0;
        end else begin
            addr_r <= raddr;
            vld1_r <= run;
        end
    end

    // The array already holds every earlier write; only this cycle's write needs forwarding.
    always_comb begin
        s2_data_s = {WORD_W{1'b0}};
        if (!vld1_r) begin
            s2_data_s = {WORD_W{1'b0}};
        end else if (wr_en && (wr_addr == addr_r)) begin
            s2_data_s = wr_data;
        end else begin
            s2_data_s = s1_rdata;
        end
    end

    // Stage 2: register the resolved word onto the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {WORD_W{1'b0}};
        end else begin
            rdata_r <= s2_data_s;
        end
    end

    assign s1_addr = addr_r;
    assign rdata   = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// 32K x 16 memory: byte-serial boot loader fills the array, then it serves
// two 2-cycle read ports and one store port for the CPU.
module mem_responder
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     raddr0,
    output logic [WORD_W-1:0] rdata0,
    input  logic [AW-1:0]     raddr1,
    output logic [WORD_W-1:0] rdata1,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              run,
    output logic [15:0]       ld_words
);

    state_e            state_r, state_nxt_s;
    logic              phase_r;
    logic [7:0]        stash_r;
    logic [AW-1:0]     ptr_r;
    logic [15:0]       ld_words_r;
    logic              run_r;
    logic              ld_ready_r;

    logic              ld_acc_s;
    logic              ld_we_s;
    logic              mem_we_s;
    logic [AW-1:0]     mem_wa_s;
    logic [WORD_W-1:0] mem_wd_s;

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     s1_addr0_s, s1_addr1_s;
    logic [WORD_W-1:0] s1_rdata0_s, s1_rdata1_s;

    assign ld_acc_s = ld_valid && ld_ready_r;

    // Next state and the single muxed write port (loader in LOAD, CPU in RUN).
    always_comb begin
        state_nxt_s = state_r;
        ld_we_s     = 1'b0;
        mem_we_s    = 1'b0;
        mem_wa_s    = ptr_r;
        mem_wd_s    = {WORD_W{1'b0}};
        case (state_r)
            LOAD: begin
                if (ld_acc_s && (phase_r || ld_last)) begin
                    ld_we_s  = 1'b1;
                    mem_we_s = 1'b1;
                    mem_wa_s = ptr_r;
                    mem_wd_s = phase_r ? {ld_byte, stash_r} : {8'h00, ld_byte};
                end else begin
                    ld_we_s  = 1'b0;
                end
                if (ld_acc_s && ld_last) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            RUN: begin
                state_nxt_s = RUN;
                if (wen) begin
                    mem_we_s = 1'b1;
                    mem_wa_s = waddr;
                    mem_wd_s = wdata;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = LOAD;
            end
        endcase
    end

    // State, loader bookkeeping and the registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= LOAD;
            phase_r    <= 1'b0;
            stash_r    <= 8'h00;
            ptr_r      <= '0;
            ld_words_r <= 16'h0000;
            run_r      <= 1'b0;
            ld_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            run_r      <= (state_nxt_s == RUN);
            ld_ready_r <= (state_nxt_s == LOAD);
            if ((state_r == LOAD) && ld_acc_s) begin
                phase_r <= ~phase_r;
                if (!phase_r) begin
                    stash_r <= ld_byte;
                end
            end
            if (ld_we_s) begin
                ptr_r      <= ptr_r + AW'(1);
                ld_words_r <= sat_inc16(ld_words_r);
            end
        end
    end

    // Array write; contents deliberately survive reset so a partial image is kept.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    assign s1_rdata0_s = mem_r[s1_addr0_s];
    assign s1_rdata1_s = mem_r[s1_addr1_s];

    mem_rd_port u_port0 (
        .clk      (clk),
        .rst      (rst),
        .run      (run_r),
        .raddr    (raddr0),
        .s1_addr  (s1_addr0_s),
        .s1_rdata (s1_rdata0_s),
        .wr_en    (mem_we_s),
        .wr_addr  (mem_wa_s),
        .wr_data  (mem_wd_s),
        .rdata    (rdata0)
    );

    mem_rd_port u_port1 (
        .clk      (clk),
        .rst      (rst),
        .run      (run_r),
        .raddr    (raddr1),
        .s1_addr  (s1_addr1_s),
        .s1_rdata (s1_rdata1_s),
        .wr_en    (mem_we_s),
        .wr_addr  (mem_wa_s),
        .wr_data  (mem_wd_s),
        .rdata    (rdata1)
    );

    assign run      = run_r;
    assign ld_ready = ld_ready_r;
    assign ld_words = ld_words_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: loading, read latency, bypass and reset-mid-load.
module tb_mem_responder;

    localparam int AW = mem_pkg::AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] raddr0, raddr1, waddr;
    logic [15:0]   rdata0, rdata1, wdata, ld_words;
    logic          wen, ld_valid, ld_ready, ld_last, run;
    logic [7:0]    ld_byte;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .raddr0   (raddr0),
        .rdata0   (rdata0),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_byte  (ld_byte),
        .ld_last  (ld_last),
        .run      (run),
        .ld_words (ld_words)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; raddr0 = '0; raddr1 = '0; waddr = '0; wdata = 16'h0000;
        wen = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;
        tick(); tick();
        chk("rst_run", {15'd0, run}, 16'h0000);
        chk("rst_ready", {15'd0, ld_ready}, 16'h0001);
        chk("rst_words", ld_words, 16'h0000);
        chk("rst_rdata0", rdata0, 16'h0000);
        chk("rst_rdata1", rdata1, 16'h0000);
        rst = 1'b0;

        // Even-length image
        send(8'h34, 1'b0);
        send(8'h12, 1'b0);
        chk("a_words1", ld_words, 16'h0001);
        chk("a_run_loading", {15'd0, run}, 16'h0000);
        send(8'h78, 1'b0);
        send(8'h56, 1'b1);
        chk("a_run", {15'd0, run}, 16'h0001);
        chk("a_ready", {15'd0, ld_ready}, 16'h0000);
        chk("a_words2", ld_words, 16'h0002);
        raddr0 = 15'd0;
        tick();
        raddr0 = 15'd1;
        chk("a_load_req_zero", rdata0, 16'h0000);
        tick();
        chk("a_rd0", rdata0, 16'h1234);
        tick();
        chk("a_rd1", rdata0, 16'h5678);

        // Odd-length image
        rst = 1'b1;
        tick();
        chk("b_rst_run", {15'd0, run}, 16'h0000);
        chk("b_rst_words", ld_words, 16'h0000);
        chk("b_rst_ready", {15'd0, ld_ready}, 16'h0001);
        chk("b_rst_rdata0", rdata0, 16'h0000);
        rst = 1'b0;
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'hAB, 1'b1);
        chk("b_words", ld_words, 16'h0002);
        chk("b_run", {15'd0, run}, 16'h0001);
        raddr1 = 15'd1;
        tick(); tick();
        chk("b_word1", rdata1, 16'h00AB);
        raddr1 = 15'd0;
        tick(); tick();
        chk("b_word0", rdata1, 16'h0001);

        // Bypass: write in t+1 is forwarded
        raddr1 = 15'd5;
        tick();
        raddr1 = 15'd0;
        wen = 1'b1; waddr = 15'd5; wdata = 16'hBEEF;
        tick();
        wen = 1'b0;
        chk("c_bypass", rdata1, 16'hBEEF);
        // Write in t+2 is not seen
        raddr1 = 15'd5;
        tick();
        raddr1 = 15'd0;
        tick();
        wen = 1'b1; waddr = 15'd5; wdata = 16'hCAFE;
        chk("c_late_write", rdata1, 16'hBEEF);
        tick();
        wen = 1'b0;
        // Write in cycle t lands before the read
        wen = 1'b1; waddr = 15'd5; wdata = 16'h2222; raddr1 = 15'd5;
        tick();
        wen = 1'b0; raddr1 = 15'd0;
        tick();
        chk("c_same_cycle", rdata1, 16'h2222);
        // Both ports forwarded
        raddr0 = 15'd5; raddr1 = 15'd5;
        tick();
        raddr0 = 15'd0; raddr1 = 15'd0;
        wen = 1'b1; waddr = 15'd5; wdata = 16'h1111;
        tick();
        wen = 1'b0;
        chk("c_both_p0", rdata0, 16'h1111);
        chk("c_both_p1", rdata1, 16'h1111);
        // Write to another address is not forwarded
        raddr0 = 15'd5;
        tick();
        raddr0 = 15'd0;
        wen = 1'b1; waddr = 15'd6; wdata = 16'h9999;
        tick();
        wen = 1'b0;
        chk("c_no_bypass", rdata0, 16'h1111);

        // Reset mid-load keeps the partial image
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        chk("d_words1", ld_words, 16'h0001);
        send(8'h33, 1'b0);
        wen = 1'b1; waddr = 15'd1; wdata = 16'hFFFF;
        tick();
        wen = 1'b0;
        chk("d_load_rdata0", rdata0, 16'h0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("d_rst_words", ld_words, 16'h0000);
        chk("d_rst_run", {15'd0, run}, 16'h0000);
        chk("d_rst_ready", {15'd0, ld_ready}, 16'h0001);
        send(8'h44, 1'b0);
        send(8'h55, 1'b1);
        chk("d_words", ld_words, 16'h0001);
        chk("d_run", {15'd0, run}, 16'h0001);
        raddr0 = 15'd0; raddr1 = 15'd1;
        tick(); tick();
        chk("d_word0", rdata0, 16'h5544);
        chk("d_word1_kept", rdata1, 16'h00AB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
